scan_test_controller: RTL
=========================

Name: scan_test_controller

Overview:
- Tester-side driver for a single internal scan chain: the controller end of a scan_en/scan_in/scan_out interface.
- Per test, it performs these steps in order:
  - Serially loads a test pattern into the chain.
  - Releases scan_en for a programmable number of functional capture clocks.
  - Unloads the captured response and compares it against an expected vector under a care mask.
- Sits beside the DUT on the test bench or in an on-chip test wrapper, sharing the DUT clock.

Parameters:
- CHAIN_LEN, 2, number of flops in the scan chain (>=1).
- CAPTURE_CYCLES, 1, number of functional clocks with scan_en low between load and unload (>=1).
- CNT_W, 8, bit width of the internal shift/capture counter; must hold max(CHAIN_LEN, CAPTURE_CYCLES).

Ports:
- clk  input  1  clock, shared with the DUT chain.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to run a test; sampled only in IDLE.
- pattern_in  input  CHAIN_LEN  stimulus to load; bit CHAIN_LEN-1 is the chain flop nearest scan_out.
- expected  input  CHAIN_LEN  expected captured response.
- care_mask  input  CHAIN_LEN  1 = compare this bit, 0 = don't-care.
- scan_en  output  1  drives DUT scan_en.
- scan_si  output  1  drives DUT scan_in.
- scan_so  input  1  from DUT scan_out (last chain flop).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the result is valid.
- pass  output  1  1 when no masked mismatch occurred; held until the next done.
- captured  output  CHAIN_LEN  unloaded response; held until the next done.
- mismatch  output  CHAIN_LEN  (captured XOR expected) AND care_mask; held until the next done.

Behaviour:
- Registered outputs:
  - scan_en, scan_si, busy, done, pass, captured and mismatch are all flop outputs.
  - Reset values: scan_en=0, scan_si=0, busy=0, done=0, pass=0, captured=0, mismatch=0.
- Chain model the controller is built for:
  - When scan_en=1, each edge shifts q <= {q[CHAIN_LEN-2:0], scan_in}.
  - scan_out = q[CHAIN_LEN-1].
  - Consequence: the first bit shifted in ends at the MSB.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - scan_en=0, busy=0.
  - On start=1, latch pattern_in, expected and care_mask into shadow registers, clear the counter, and go to SHIFT_IN.
- SHIFT_IN, exactly CHAIN_LEN cycles:
  - scan_en=1.
  - In cycle k (k=0..CHAIN_LEN-1), scan_si = pattern[CHAIN_LEN-1-k], so MSB goes first.
  - After the last cycle's edge, the chain holds the pattern.
- CAPTURE, exactly CAPTURE_CYCLES cycles:
  - scan_en=0, scan_si=0; the DUT runs functionally.
- SHIFT_OUT, exactly CHAIN_LEN cycles:
  - scan_en=1, scan_si=0.
  - On the edge ending cycle k, sample scan_so into captured bit CHAIN_LEN-1-k; this is the pre-shift value, so the MSB comes first.
- DONE, 1 cycle:
  - done=1, busy still 1.
  - captured, mismatch and pass are updated at the edge entering DONE.
  - Unconditionally returns to IDLE.
- Latency: done is high in cycle 2*CHAIN_LEN+CAPTURE_CYCLES+1 after the edge that accepted start.
- The earliest back-to-back start is the cycle after done (IDLE).
- start while not in IDLE is ignored, with no queueing.
- Input changes to pattern_in, expected or care_mask after acceptance have no effect on the running test.
- care_mask=0 forces pass=1 regardless of scan_so.
- Asynchronous reset mid-operation:
  - FSM returns to IDLE immediately and scan_en drops to 0 with no glitch through a shift.
  - Result registers clear, and no done pulse is generated.
- An illegal FSM encoding recovers to IDLE.

Test Plan:
- Bench chain model: CHAIN_LEN=2, CAPTURE_CYCLES=1. Functional next-state is 00->01, 01->10, 10->00, 11->00.
  - Load 00, expected 01, mask 11 -> captured=01, mismatch=00, pass=1.
  - done occurs at cycle 6 after start.
- Load 01, expected 10 -> pass=1.
- Load 10, expected 00 -> pass=1.
- Check scan_si sequence for load 10: 1 then 0, with scan_en high for exactly 2 cycles, then 1 low, then 2 high.
- Load 11, expected 11, mask 11 -> captured=00, mismatch=11, pass=0.
  - Same test with mask 00 -> pass=1, mismatch=00.
- start held high during a test: only one done per accepted start.
  - Changing pattern_in mid-test does not alter the scan_si sequence.
  - A new start the cycle after done is accepted.
- Assert rst in the second SHIFT_IN cycle:
  - scan_en=0 and busy=0 immediately; no done.
  - The next full test produces correct results.
- CHAIN_LEN=8, CAPTURE_CYCLES=3, scan_so looped from an 8-flop identity chain (capture holds the value), pattern 0xA5, expected 0xA5:
  - pass=1; done at cycle 20 after start.

Source files
------------

// File: rtl/scan_test_controller.sv
// Tester-side scan chain driver: loads a pattern MSB-first, runs functional capture
// clocks, then unloads the response and checks it against expected under a care mask.
module scan_test_controller #(
  parameter int CHAIN_LEN      = 2,
  parameter int CAPTURE_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] care_mask,
  output logic                 scan_en,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured,
  output logic [CHAIN_LEN-1:0] mismatch
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] SHIFT_OUT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]           state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [CHAIN_LEN-1:0] pat_r;
  logic [CHAIN_LEN-1:0] exp_r;
  logic [CHAIN_LEN-1:0] mask_r;
  logic [CHAIN_LEN-1:0] cap_r;
  logic [CHAIN_LEN-1:0] cap_next_s;
  logic [CHAIN_LEN-1:0] diff_next_s;

  function automatic logic [CHAIN_LEN-1:0] masked_diff(
    input logic [CHAIN_LEN-1:0] a,
    input logic [CHAIN_LEN-1:0] b,
    input logic [CHAIN_LEN-1:0] m
  );
    return (a ^ b) & m;
  endfunction

  // Unload shift register: the first bit sampled from the chain lands at the MSB.
  always_comb begin
    cap_next_s  = (cap_r << 1'b1) | CHAIN_LEN'(scan_so);
    diff_next_s = masked_diff(cap_next_s, exp_r, mask_r);
  end

  // Sequencer; scan_en/scan_si are registered one edge ahead so they are valid for the whole cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      pat_r    <= {CHAIN_LEN{1'b0}};
      exp_r    <= {CHAIN_LEN{1'b0}};
      mask_r   <= {CHAIN_LEN{1'b0}};
      cap_r    <= {CHAIN_LEN{1'b0}};
      scan_en  <= 1'b0;
      scan_si  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= {CHAIN_LEN{1'b0}};
      mismatch <= {CHAIN_LEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat_r   <= pattern_in << 1'b1;
            exp_r   <= expected;
            mask_r  <= care_mask;
            cnt_r   <= {CNT_W{1'b0}};
            cap_r   <= {CHAIN_LEN{1'b0}};
            scan_en <= 1'b1;
            scan_si <= pattern_in[CHAIN_LEN-1];
            busy    <= 1'b1;
            state_r <= SHIFT_IN;
          end else begin
            scan_en <= 1'b0;
            scan_si <= 1'b0;
            busy    <= 1'b0;
          end
        end
        SHIFT_IN: begin
          if (cnt_r == SHIFT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            scan_en <= 1'b0;
            scan_si <= 1'b0;
            state_r <= CAPTURE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            scan_si <= pat_r[CHAIN_LEN-1];
            pat_r   <= pat_r << 1'b1;
          end
        end
        CAPTURE: begin
          scan_si <= 1'b0;
          if (cnt_r == CAP_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            scan_en <= 1'b1;
            state_r <= SHIFT_OUT;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            scan_en <= 1'b0;
          end
        end
        SHIFT_OUT: begin
          cap_r   <= cap_next_s;
          scan_si <= 1'b0;
          if (cnt_r == SHIFT_LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            scan_en  <= 1'b0;
            captured <= cap_next_s;
            mismatch <= diff_next_s;
            pass     <= ~|diff_next_s;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            scan_en <= 1'b1;
          end
        end
        DONE: begin
          scan_en <= 1'b0;
          scan_si <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          scan_en <= 1'b0;
          scan_si <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
